// File: rtl/sdram_rd_burst.sv
// Read-path front end: watches the read FIFO fill level, requests fixed-length
// SDRAM burst reads over a circular address window and pushes returned beats into the FIFO.
module sdram_rd_burst #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 24,
  parameter int BURST_LEN  = 8,
  parameter int NUM_WIDTH  = 10,
  parameter int LOW_WATER  = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic                  addr_load,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_ack,
  input  logic                  rd_data_vld,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  fifo_wr_req,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  input  logic [NUM_WIDTH-1:0]  fifo_wr_num,
  input  logic                  fifo_wr_full,
  output logic                  busy,
  output logic                  ovf
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [NUM_WIDTH:0]  LOW_W   = (NUM_WIDTH+1)'(LOW_WATER);
  localparam logic [CNT_W-1:0]    LAST    = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH:0] BL_STEP = (ADDR_WIDTH+1)'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  typedef struct packed {
    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
  } rd_cmd_t;

  state_t                state, state_nxt;
  rd_cmd_t               cmd;
  logic [ADDR_WIDTH-1:0] ptr, ptr_adv;
  logic [ADDR_WIDTH:0]   ptr_sum;
  logic [CNT_W-1:0]      cnt;
  logic                  pend, start, last_beat;

  always_comb begin
    start     = rd_en && ({1'b0, fifo_wr_num} < LOW_W) && !fifo_wr_full;
    last_beat = (state == DATA) && rd_data_vld && (cnt == LAST);
    // Extra carry bit catches windows that end at the top of the address space.
    ptr_sum   = {1'b0, ptr} + BL_STEP;
    ptr_adv   = (ptr_sum[ADDR_WIDTH] || (ptr_sum[ADDR_WIDTH-1:0] > end_addr))
                ? base_addr : ptr_sum[ADDR_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = REQ;
      REQ:     if (rd_ack)    state_nxt = DATA;
      DATA:    if (last_beat) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    rd_req  = cmd.req;
    rd_addr = cmd.addr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd          <= '0;
      ptr          <= '0;
      cnt          <= '0;
      pend         <= 1'b0;
      fifo_wr_req  <= 1'b0;
      fifo_wr_data <= '0;
      ovf          <= 1'b0;
    end else begin
      fifo_wr_req <= 1'b0;
      case (state)
        IDLE: begin
          if (addr_load) ptr <= base_addr;
          if (start) begin
            cmd.req  <= 1'b1;
            cmd.addr <= ptr;
          end
        end
        REQ: begin
          if (rd_ack) begin
            cmd.req <= 1'b0;
            cnt     <= '0;
          end
        end
        DATA: begin
          if (rd_data_vld) begin
            cnt <= cnt + 1'b1;
            // A beat arriving while the FIFO is full is still counted so the burst ends on time.
            if (!fifo_wr_full) begin
              fifo_wr_req  <= 1'b1;
              fifo_wr_data <= rd_data;
            end
          end
          if (last_beat) begin
            ptr  <= (pend || addr_load) ? base_addr : ptr_adv;
            pend <= 1'b0;
          end
        end
        default: ;
      endcase
      if (addr_load && (state != IDLE) && !last_beat) pend <= 1'b1;
      if (rd_data_vld && ((state != DATA) || fifo_wr_full)) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_rd_burst.sv
// Directed bench for sdram_rd_burst: burst sequencing, window wrap, low-water gating,
// FIFO-full drop, deferred address load and reset mid-burst.
module tb_sdram_rd_burst;

  logic        clk = 1'b0;
  logic        rst_n, rd_en, addr_load, rd_ack, rd_data_vld, fifo_wr_full;
  logic [23:0] base_addr, end_addr, rd_addr;
  logic [15:0] rd_data, fifo_wr_data;
  logic [9:0]  fifo_wr_num;
  logic        rd_req, fifo_wr_req, busy, ovf;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sdram_rd_burst dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .base_addr(base_addr), .end_addr(end_addr),
    .addr_load(addr_load), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data_vld(rd_data_vld), .rd_data(rd_data), .fifo_wr_req(fifo_wr_req),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_num(fifo_wr_num), .fifo_wr_full(fifo_wr_full),
    .busy(busy), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One burst as the SDRAM engine sees it; -1 disables the optional events.
  task automatic burst(input logic [23:0] a, input logic [15:0] d0,
                       input int full_b, input int load_b, input int rst_b);
    int n = 0;
    while (!rd_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(rd_req), 1);
    if (!rd_req) return;
    chk("rd_addr", 32'(rd_addr), 32'(a));
    @(negedge clk);
    chk("req_hold", 32'(rd_req), 1);
    chk("addr_hold", 32'(rd_addr), 32'(a));
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    chk("req_drop", 32'(rd_req), 0);
    chk("busy_data", 32'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      rd_data_vld  = 1'b1;
      rd_data      = d0 + 16'(i);
      fifo_wr_full = (i == full_b);
      addr_load    = (i == load_b);
      if (i == rst_b) begin
        rst_n = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        rst_n        = 1'b1;
        fifo_wr_full = 1'b0;
        addr_load    = 1'b0;
        return;
      end
      @(negedge clk);
      chk("wr_req", 32'(fifo_wr_req), 32'(i != full_b));
      if (i != full_b) chk("wr_data", 32'(fifo_wr_data), 32'(d0 + 16'(i)));
    end
    rd_data_vld  = 1'b0;
    fifo_wr_full = 1'b0;
    addr_load    = 1'b0;
    chk("idle_after", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; addr_load = 1'b0; rd_ack = 1'b0;
    rd_data_vld = 1'b0; rd_data = '0; fifo_wr_full = 1'b0; fifo_wr_num = '0;
    base_addr = 24'h000100; end_addr = 24'h0001FF;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(rd_req), 0);
    chk("rst_addr", 32'(rd_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_wr", 32'(fifo_wr_req), 0);
    chk("rst_wdata", 32'(fifo_wr_data), 0);

    rst_n = 1'b1;
    addr_load = 1'b1;
    @(negedge clk);
    addr_load = 1'b0;
    chk("idle_no_en", 32'(busy), 0);
    rd_en = 1'b1;

    for (int k = 0; k < 32; k++)
      burst(24'h000100 + 24'(8 * k), 16'hA000 + 16'(8 * k), -1, -1, -1);

    fifo_wr_num = 10'd512;
    repeat (4) begin
      @(negedge clk);
      chk("lw_noreq", 32'(rd_req), 0);
    end
    fifo_wr_num = 10'd511;
    @(negedge clk);
    chk("lw_req", 32'(rd_req), 1);
    fifo_wr_num = '0;
    burst(24'h000100, 16'h5000, -1, -1, -1);

    burst(24'h000108, 16'hB000, 3, -1, -1);
    chk("ovf_full", 32'(ovf), 1);

    base_addr = 24'h000400;
    end_addr  = 24'h0004FF;
    burst(24'h000110, 16'hC000, -1, 2, -1);
    chk("ovf_sticky", 32'(ovf), 1);
    burst(24'h000400, 16'hD000, -1, -1, -1);

    burst(24'h000408, 16'hE000, -1, -1, 5);
    chk("mrst_req", 32'(rd_req), 0);
    chk("mrst_addr", 32'(rd_addr), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_ovf", 32'(ovf), 0);
    chk("mrst_wr", 32'(fifo_wr_req), 0);
    chk("mrst_wdata", 32'(fifo_wr_data), 0);
    @(negedge clk);
    chk("stray_ovf", 32'(ovf), 1);
    chk("stray_busy", 32'(busy), 0);
    chk("stray_wr", 32'(fifo_wr_req), 0);
    rd_data_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("stay_idle", 32'(busy), 0);
    chk("stay_noreq", 32'(rd_req), 0);
    rd_en = 1'b1;
    @(negedge clk);
    chk("post_rst_req", 32'(rd_req), 1);
    chk("post_rst_addr", 32'(rd_addr), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sdram_rd_burst.md
Name: sdram_rd_burst

Overview:
- Read-path front end of the SDRAM controller. The user-side read FIFO is drained by the user; this block keeps it fed.
- It monitors the FIFO fill level and issues fixed-length burst read requests to the SDRAM command engine. It walks a circular address window.
- Returned read beats are pushed into the read FIFO's write port.
- It is the counterpart of the write path, which drains the write FIFO into SDRAM.

Parameters:
- DATA_WIDTH, 16, width of SDRAM/FIFO data word
- ADDR_WIDTH, 24, SDRAM word-address width
- BURST_LEN, 8, beats per burst read (power of 2, 1..256)
- NUM_WIDTH, 10, width of FIFO fill-level input
- LOW_WATER, 512, a burst is requested only when fifo_wr_num < LOW_WATER

Ports:
- clk  in  1  single clock, shared by SDRAM core and FIFO write port
- rst_n  in  1  synchronous active-low reset
- rd_en  in  1  level; 1 = keep FIFO topped up
- base_addr  in  ADDR_WIDTH  first word of circular read window
- end_addr  in  ADDR_WIDTH  last word of window (inclusive)
- addr_load  in  1  pulse; reload pointer from base_addr
- rd_req  out  1  burst read request to SDRAM engine
- rd_addr  out  ADDR_WIDTH  burst start address, stable while rd_req=1
- rd_ack  in  1  one-cycle acceptance of rd_req
- rd_data_vld  in  1  returned read beat valid
- rd_data  in  DATA_WIDTH  returned read beat
- fifo_wr_req  out  1  FIFO write strobe
- fifo_wr_data  out  DATA_WIDTH  FIFO write data
- fifo_wr_num  in  NUM_WIDTH  FIFO fill level, write-clock view
- fifo_wr_full  in  1  FIFO full
- busy  out  1  1 when state != IDLE
- ovf  out  1  sticky error flag

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE
  - rd_req=0, rd_addr=0, pointer=0, beat counter=0
  - fifo_wr_req=0, fifo_wr_data=0, busy=0, ovf=0
  - pending-load flag=0
  - Reset mid-burst abandons the burst. Beats arriving later are not counted; they set ovf only after reset deasserts.
- FSM states: IDLE, REQ, DATA.
- IDLE -> REQ when rd_en=1 && fifo_wr_num < LOW_WATER && fifo_wr_full=0.
  - On entry, rd_addr <= pointer and rd_req <= 1 (registered, 1-cycle latency from condition).
- REQ:
  - Hold rd_req=1 and rd_addr stable until rd_ack=1.
  - On rd_ack: rd_req <= 0, beat counter <= 0, go DATA.
  - rd_en falling in REQ does not retract the request.
- DATA:
  - Each rd_data_vld=1 cycle: fifo_wr_req <= 1, fifo_wr_data <= rd_data (1-cycle latency), beat counter +1. Otherwise fifo_wr_req <= 0.
  - After beat BURST_LEN: go IDLE and advance the pointer.
  - rd_en falling in DATA: the burst completes normally.
- Pointer advance:
  - next = pointer + BURST_LEN, computed in ADDR_WIDTH+1 bits.
  - If next > end_addr, or the carry bit is set: pointer <= base_addr. Else pointer <= next.
  - A burst is never split; the window length is required to be a multiple of BURST_LEN.
- addr_load:
  - In IDLE: pointer <= base_addr next cycle.
  - In REQ/DATA: sets the pending flag. The load is applied on return to IDLE and overrides the pointer advance. The flag then clears.
- Overflow:
  - rd_data_vld=1 while fifo_wr_full=1: beat is dropped (fifo_wr_req stays 0), still counted, ovf <= 1.
  - rd_data_vld=1 in IDLE or REQ: ignored, ovf <= 1.
  - ovf clears only on reset.
- Back-to-back: the earliest next rd_req is the cycle after returning to IDLE. Minimum one IDLE cycle between bursts.
- busy is combinational from state.

Test Plan:
- Reset, rd_en=1, base=0x000100, end=0x0001FF, fifo_wr_num=0, engine acks after 2 cycles and returns 8 consecutive beats 0xA000..0xA007 -> rd_req with rd_addr=0x000100; exactly 8 fifo_wr_req pulses, each 1 cycle after the matching rd_data_vld, data 0xA000..0xA007; next rd_addr=0x000108.
- Run 32 bursts over the same window -> rd_addr sequence 0x100, 0x108 … 0x1F8, then 0x100 (wrap); no burst crosses 0x1FF.
- fifo_wr_num=512 -> no rd_req. Drop fifo_wr_num to 511 -> rd_req 1 cycle later.
- Assert fifo_wr_full during beat 3 of 8 -> beat 3 is not written, ovf=1 and stays 1; burst still ends after 8 beats.
- Pulse addr_load in DATA with base_addr changed to 0x000400 -> current burst finishes; next rd_addr=0x000400.
- rst_n=0 for 1 cycle during DATA beat 5 -> all outputs at reset values; later stray beats set ovf=1; FSM stays in IDLE until the request condition holds again.
